psg_voice_engine: RTL and testbench

PSG_VOICE_ENGINE -- requirements
Module: psg_voice_engine

---
 rtl/psg_voice_engine.sv | 84 ++++++++
 tb/tb_psg_voice_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/psg_voice_engine.sv
// psg_voice_engine: 16-voice PSG mixer that walks the attribute RAM once per frame
// and produces a signed stereo sample 17 clocks after each frame strobe.
module psg_voice_engine (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               next_sample_i,
  output logic [3:0]         attr_rd_addr_o,
  input  logic [31:0]        attr_rd_data_i,
  output logic signed [15:0] left_o,
  output logic signed [15:0] right_o,
  output logic               valid_o,
  output logic               busy_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]         state;
  logic [4:0]         cnt;
  logic [15:0]        lfsr;
  logic [16:0]        phase [16];
  logic signed [15:0] acc_l, acc_r;
  logic [15:0]        freq;
  logic [5:0]         vol, pw, samp, tri_s;
  logic [1:0]         wave;
  logic [3:0]         vidx;
  logic [16:0]        ph;
  logic signed [15:0] sc, vol_s, contrib, nl, nr;
  assign busy_o = state == RUN;
  assign freq   = attr_rd_data_i[15:0];
  assign vol    = attr_rd_data_i[21:16];
  assign pw     = attr_rd_data_i[29:24];
  assign wave   = attr_rd_data_i[31:30];
  // cnt holds the number of edges since the strobe; the voice consumed now was addressed two edges ago
  assign vidx   = cnt[3:0] - 4'd1;
  assign ph     = phase[vidx];
  assign tri_s  = ph[16] ? ~ph[15:10] : ph[15:10];
  assign samp   = wave == 2'd0 ? ((ph[16:10] < {pw, 1'b0}) ? 6'd63 : 6'd0) :
                  wave == 2'd1 ? ph[16:11] :
                  wave == 2'd2 ? tri_s : lfsr[5:0];
  assign sc      = {10'd0, samp} - 16'sd32;
  assign vol_s   = {10'd0, vol};
  assign contrib = sc * vol_s;
  assign nl      = acc_l + (attr_rd_data_i[22] ? contrib : 16'sd0);
  assign nr      = acc_r + (attr_rd_data_i[23] ? contrib : 16'sd0);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      cnt            <= '0;
      attr_rd_addr_o <= '0;
      left_o         <= '0;
      right_o        <= '0;
      valid_o        <= 1'b0;
      acc_l          <= '0;
      acc_r          <= '0;
      lfsr           <= 16'h0001;
      for (int i = 0; i < 16; i++) phase[i] <= '0;
    end else begin
      valid_o <= 1'b0;
      if (state == IDLE) begin
        if (next_sample_i) begin
          state          <= RUN;
          cnt            <= '0;
          attr_rd_addr_o <= '0;
          acc_l          <= '0;
          acc_r          <= '0;
        end
      end else begin
        lfsr           <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        cnt            <= cnt + 5'd1;
        attr_rd_addr_o <= attr_rd_addr_o == 4'd15 ? attr_rd_addr_o : attr_rd_addr_o + 4'd1;
        if (cnt != 5'd0) begin
          phase[vidx] <= ph + {1'b0, freq};
          acc_l       <= nl;
          acc_r       <= nr;
        end
        if (cnt == 5'd16) begin
          left_o  <= nl;
          right_o <= nr;
          valid_o <= 1'b1;
          state   <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_psg_voice_engine.sv
// tb_psg_voice_engine: directed and random frames checked against an arithmetic reference model.
module tb_psg_voice_engine;
  logic               clk_i = 1'b0, rst_n_i = 1'b0, next_sample_i = 1'b0;
  logic [3:0]         attr_rd_addr_o;
  logic [31:0]        attr_rd_data_i = '0;
  logic signed [15:0] left_o, right_o;
  logic               valid_o, busy_o;
  logic [31:0]        mem [16];
  int                 tests = 0, fails = 0;
  int                 m_ph [16];
  logic [15:0]        m_lf;

  psg_voice_engine dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .next_sample_i(next_sample_i),
    .attr_rd_addr_o(attr_rd_addr_o), .attr_rd_data_i(attr_rd_data_i),
    .left_o(left_o), .right_o(right_o), .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) attr_rd_data_i <= mem[attr_rd_addr_o];

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] attr(input int wave, input int pw, input bit r, input bit l,
                                       input int vol, input int freq);
    return {wave[1:0], pw[5:0], r, l, vol[5:0], freq[15:0]};
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 16; v++) m_ph[v] = 0;
    m_lf = 16'h0001;
  endtask

  // One noise step per busy clock; voice v sees the register after v+1 steps, 17 steps per frame.
  task automatic model(output int el, output int er);
    int l = 0, r = 0;
    for (int v = 0; v < 16; v++) begin
      int ph, s, c, w, pw, vol;
      m_lf = {m_lf[14:0], ^(m_lf & 16'hB400)};
      ph  = m_ph[v];
      w   = int'(mem[v][31:30]);
      pw  = int'(mem[v][29:24]);
      vol = int'(mem[v][21:16]);
      case (w)
        0: s = ((ph / 1024) < pw * 2) ? 63 : 0;
        1: s = ph / 2048;
        2: s = ph >= 65536 ? 63 - ((ph / 1024) % 64) : (ph / 1024) % 64;
        default: s = int'(m_lf) % 64;
      endcase
      c = (s - 32) * vol;
      if (mem[v][22]) l += c;
      if (mem[v][23]) r += c;
      m_ph[v] = (ph + int'(mem[v][15:0])) % 131072;
    end
    m_lf = {m_lf[14:0], ^(m_lf & 16'hB400)};
    el = int'($signed(16'(l)));
    er = int'($signed(16'(r)));
  endtask

  // Caller is at a negedge; strobe is sampled on the next posedge (E0).
  task automatic frame(input string tag, input bit extra, output int lo, output int ro);
    int lat = 0, bz = 0, el, er;
    next_sample_i = 1'b1;
    @(negedge clk_i);
    next_sample_i = 1'b0;
    while (!valid_o && lat < 40) begin
      if (busy_o) bz++;
      chk({tag, "_addr"}, int'(attr_rd_addr_o), lat > 15 ? 15 : lat);
      next_sample_i = extra && (lat == 3 || lat == 10);
      @(negedge clk_i);
      lat++;
    end
    next_sample_i = 1'b0;
    chk({tag, "_latency"}, lat, 17);
    chk({tag, "_busy_cycles"}, bz, 17);
    chk({tag, "_busy_end"}, int'(busy_o), 0);
    model(el, er);
    lo = int'(left_o);
    ro = int'(right_o);
    chk({tag, "_left_model"}, lo, el);
    chk({tag, "_right_model"}, ro, er);
  endtask

  initial begin
    int lo, ro, nv;
    for (int v = 0; v < 16; v++) mem[v] = '0;
    model_reset();
    repeat (3) @(negedge clk_i);
    chk("rst_addr", int'(attr_rd_addr_o), 0);
    chk("rst_left", int'(left_o), 0);
    chk("rst_right", int'(right_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    frame("zero", 1'b0, lo, ro);
    chk("zero_left", lo, 0);
    chk("zero_right", ro, 0);
    @(negedge clk_i);
    chk("valid_one_cycle", int'(valid_o), 0);

    mem[0] = attr(1, 0, 1, 1, 63, 16'h0800);
    frame("saw1", 1'b0, lo, ro);
    chk("saw1_left", lo, -2016);
    chk("saw1_right", ro, -2016);
    frame("saw2", 1'b0, lo, ro);
    chk("saw2_left", lo, -1953);
    frame("saw3", 1'b0, lo, ro);
    chk("saw3_right", ro, -1890);
    @(negedge clk_i);
    chk("hold_left", int'(left_o), -1890);

    mem[0] = '0;
    mem[5] = attr(0, 32, 0, 1, 10, 0);
    frame("pulse5", 1'b0, lo, ro);
    chk("pulse5_left", lo, 310);
    chk("pulse5_right", ro, 0);

    for (int v = 0; v < 16; v++) mem[v] = attr(0, 63, 1, 1, 63, 0);
    for (int f = 0; f < 2; f++) begin
      frame("full", 1'b0, lo, ro);
      chk("full_left", lo, 31248);
      chk("full_right", ro, 31248);
    end

    frame("ignore", 1'b1, lo, ro);
    frame("back2back", 1'b0, lo, ro);
    nv = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (valid_o) nv++;
    end
    chk("no_extra_valid", nv, 0);

    for (int v = 0; v < 16; v++) mem[v] = '0;
    mem[0] = attr(1, 0, 1, 1, 63, 16'h0800);
    next_sample_i = 1'b1;
    @(negedge clk_i);
    next_sample_i = 1'b0;
    repeat (8) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    chk("abort_left", int'(left_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    nv = 0;
    repeat (12) begin
      @(negedge clk_i);
      if (valid_o) nv++;
    end
    chk("abort_no_valid", nv, 0);
    chk("abort_right", int'(right_o), 0);
    chk("abort_addr", int'(attr_rd_addr_o), 0);
    rst_n_i = 1'b1;
    model_reset();
    @(negedge clk_i);
    frame("after_rst", 1'b0, lo, ro);
    chk("after_rst_left", lo, -2016);
    chk("after_rst_right", ro, -2016);

    for (int f = 0; f < 12; f++) begin
      for (int v = 0; v < 16; v++) mem[v] = $urandom;
      frame("rand", 1'b0, lo, ro);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
